// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter and cycle sequencer for the external 256K x 16 asynchronous
// SRAM. Port H (host path) has priority. Port D (DMA/video) is forced through
// after STARVE_LIMIT consecutive H grants that were made while D was waiting.
// This block owns every SRAM control pin, so each requester sees a plain word
// interface.
//
// Requester handshake (both ports):
//   req is raised with we/be/addr/wdata stable and is held until ack. ack is a
//   one-cycle pulse that marks completion; for a read, rdata is valid while ack
//   is high and holds until the next read completes on that port. The requester
//   drops req on the edge after it sees ack. A req still high when the
//   sequencer is back in IDLE is taken as a new request.
//
// Parameters:
//   RD_CYCLES    cycles CS/OE are held low before read data is sampled (1-15)
//   WR_CYCLES    cycles WE is held low (1-15)
//   STARVE_LIMIT consecutive H grants with D waiting before D is forced (1-15)
//
// Ports:
//   clk                      system clock
//   reset                    asynchronous, active-low reset
//   h_req/h_we/h_be/h_addr/h_wdata   host request channel
//   d_req/d_we/d_be/d_addr/d_wdata   DMA request channel
//   h_ack/h_rdata, d_ack/d_rdata     per-port completion and read data
//   sram_addr/sram_dout/sram_din     SRAM address and data pins
//   sram_oe_en                       output enable for the DAT pad drivers
//   ram_cs_n/ram_oe_n/ram_we_n/ram_lb_n/ram_ub_n  SRAM controls, active-low
//   state                            FSM state for the debug header
//
// Every output is driven straight from a register.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int unsigned RD_CYCLES    = 2,
    parameter int unsigned WR_CYCLES    = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        h_req,
    input  logic        h_we,
    input  logic [1:0]  h_be,
    input  logic [17:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic        h_ack,
    output logic [15:0] h_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_be,
    input  logic [17:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,

    output logic [17:0] sram_addr,
    output logic [15:0] sram_dout,
    input  logic [15:0] sram_din,
    output logic        sram_oe_en,
    output logic        ram_cs_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        ram_lb_n,
    output logic        ram_ub_n,

    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WSETUP = 3'd2,
        ST_WPULSE = 3'd3,
        ST_WHOLD  = 3'd4,
        ST_TURN   = 3'd5
    } state_t;

    localparam logic [3:0] RD_LOAD    = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD    = 4'(WR_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Registered state
    state_t      state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic        port_q,   port_d;     // 0 = H, 1 = D
    logic [3:0]  starve_q, starve_d;
    logic [17:0] addr_q,   addr_d;
    logic [15:0] wdata_q,  wdata_d;
    logic        cs_n_q,   cs_n_d;
    logic        oe_n_q,   oe_n_d;
    logic        we_n_q,   we_n_d;
    logic        lb_n_q,   lb_n_d;
    logic        ub_n_q,   ub_n_d;
    logic        oe_en_q,  oe_en_d;
    logic        h_ack_q,  h_ack_d;
    logic        d_ack_q,  d_ack_d;
    logic [15:0] h_rdata_q, h_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;

    // Arbitration: D wins when it is alone, or when H has been granted
    // STARVE_LIMIT times in a row while D was waiting.
    logic        pick_d;
    logic        sel_we;
    logic [1:0]  sel_be;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;

    assign pick_d    = d_req & (~h_req | (starve_q == STARVE_MAX));
    assign sel_we    = pick_d ? d_we    : h_we;
    assign sel_be    = pick_d ? d_be    : h_be;
    assign sel_addr  = pick_d ? d_addr  : h_addr;
    assign sel_wdata = pick_d ? d_wdata : h_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            port_q    <= 1'b0;
            starve_q  <= 4'd0;
            addr_q    <= 18'd0;
            wdata_q   <= 16'd0;
            cs_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            oe_en_q   <= 1'b0;
            h_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            h_rdata_q <= 16'd0;
            d_rdata_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            port_q    <= port_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_n_q    <= cs_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            oe_en_q   <= oe_en_d;
            h_ack_q   <= h_ack_d;
            d_ack_q   <= d_ack_d;
            h_rdata_q <= h_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        starve_d  = starve_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cs_n_d    = cs_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        oe_en_d   = oe_en_q;
        h_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        h_rdata_d = h_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (h_req || d_req) begin
                    port_d  = pick_d;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // Byte lanes are latched straight into the strobe
                    // registers; be == 2'b00 runs a full cycle with no lane.
                    cs_n_d  = 1'b0;
                    lb_n_d  = ~sel_be[0];
                    ub_n_d  = ~sel_be[1];

                    if (pick_d) begin
                        starve_d = 4'd0;
                    end else if (d_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end

                    if (sel_we) begin
                        state_d = ST_WSETUP;
                        we_n_d  = 1'b1;
                        oe_en_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                    end
                end
            end

            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_TURN;
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    if (port_q) begin
                        d_rdata_d = sram_din;
                        d_ack_d   = 1'b1;
                    end else begin
                        h_rdata_d = sram_din;
                        h_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WSETUP: begin
                // Address and data have had one cycle to settle before WE falls.
                state_d = ST_WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = WR_LOAD;
            end

            ST_WPULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WHOLD;
                    we_n_d  = 1'b1;
                    if (port_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        h_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WHOLD: begin
                // Data stays driven for the cycle after WE rises (hold time).
                state_d = ST_TURN;
                cs_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                oe_en_d = 1'b0;
            end

            ST_TURN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                oe_en_d = 1'b0;
            end
        endcase
    end

    assign state      = state_q;
    assign sram_addr  = addr_q;
    assign sram_dout  = wdata_q;
    assign sram_oe_en = oe_en_q;
    assign ram_cs_n   = cs_n_q;
    assign ram_oe_n   = oe_n_q;
    assign ram_we_n   = we_n_q;
    assign ram_lb_n   = lb_n_q;
    assign ram_ub_n   = ub_n_q;
    assign h_ack      = h_ack_q;
    assign d_ack      = d_ack_q;
    assign h_rdata    = h_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. Two requester queues feed the DUT; an
// SRAM array answers reads. A reference model tracks each granted access as an
// offset from its grant edge and derives every expected pin value, ack and
// read-data word from the access timeline. Completed accesses are also pushed
// into an expected queue and matched against the DUT's acks.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int RD = 2;
    localparam int WR = 2;
    localparam int SL = 4;

    typedef struct packed {
        logic        we;
        logic [1:0]  be;
        logic [17:0] addr;
        logic [15:0] wdata;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic        h_req, h_we, d_req, d_we;
    logic [1:0]  h_be, d_be;
    logic [17:0] h_addr, d_addr;
    logic [15:0] h_wdata, d_wdata;
    logic        h_ack, d_ack;
    logic [15:0] h_rdata, d_rdata;
    logic [17:0] sram_addr;
    logic [15:0] sram_dout, sram_din;
    logic        sram_oe_en, ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
    logic [2:0]  state;

    sram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_be(h_be), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_oe_en(sram_oe_en), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
        .state(state)
    );

    // SRAM contents; only driven onto the bus while CS and OE are both low.
    logic [15:0] mem [0:262143];
    assign sram_din = (!ram_cs_n && !ram_oe_n) ? mem[sram_addr] : 16'hDEAD;

    // ---------------- stimulus queues and reference model ----------------
    txn_t hq[$];
    txn_t dq[$];

    bit          m_busy;
    int          m_k;
    bit          m_we;
    bit          m_port;
    logic [1:0]  m_be;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    int          m_starve;
    logic [15:0] m_h_rdata, m_d_rdata;

    logic [16:0] exp_q[$];
    bit          log_en;
    bit          ack_log[$];
    int          n_we_low, n_oe_en, n_dack;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.be    = 2'($urandom_range(0, 3));
        t.addr  = 18'($urandom_range(0, 15));
        t.wdata = 16'($urandom);
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_ports();
        h_req = (hq.size() != 0);
        d_req = (dq.size() != 0);
        if (h_req) begin
            h_we = hq[0].we; h_be = hq[0].be; h_addr = hq[0].addr; h_wdata = hq[0].wdata;
        end else begin
            h_we = 1'($urandom); h_be = 2'($urandom); h_addr = 18'($urandom); h_wdata = 16'($urandom);
        end
        if (d_req) begin
            d_we = dq[0].we; d_be = dq[0].be; d_addr = dq[0].addr; d_wdata = dq[0].wdata;
        end else begin
            d_we = 1'($urandom); d_be = 2'($urandom); d_addr = 18'($urandom); d_wdata = 16'($urandom);
        end
    endtask

    // Advance the model across one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        txn_t t;
        bit   take_d;
        if (m_busy) begin
            m_k++;
            if (!m_we && m_k == RD) begin
                if (m_port) m_d_rdata = mem[m_addr];
                else        m_h_rdata = mem[m_addr];
                exp_q.push_back({m_port, mem[m_addr]});
            end
            if (m_we && m_k == WR + 1) begin
                if (m_be[0]) mem[m_addr][7:0]  = m_wdata[7:0];
                if (m_be[1]) mem[m_addr][15:8] = m_wdata[15:8];
                exp_q.push_back({m_port, m_port ? m_d_rdata : m_h_rdata});
            end
            if (m_k == (m_we ? WR + 3 : RD + 1)) m_busy = 0;
        end else if (h_req || d_req) begin
            take_d = d_req && (!h_req || m_starve == SL);
            t = take_d ? dq[0] : hq[0];
            if (take_d)                        m_starve = 0;
            else if (d_req && m_starve < SL)   m_starve++;
            m_busy  = 1;
            m_k     = 0;
            m_port  = take_d;
            m_we    = t.we;
            m_be    = t.be;
            m_addr  = t.addr;
            m_wdata = t.wdata;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_starve = 0;
        m_h_rdata = 16'h0; m_d_rdata = 16'h0;
        exp_q.delete();
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_match(input bit port, input logic [15:0] rd);
        chk("sb_ack_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk(port ? "sb_d" : "sb_h", {15'd0, port, rd}, {15'd0, exp_q.pop_front()});
        if (log_en) ack_log.push_back(port);
    endtask

    task automatic check_cycle();
        logic       e_cs_n, e_oe_n, e_we_n, e_oe_en, e_hack, e_dack;
        logic [2:0] e_state;
        e_cs_n = 1; e_oe_n = 1; e_we_n = 1; e_oe_en = 0; e_hack = 0; e_dack = 0; e_state = 3'd0;
        if (m_busy) begin
            if (!m_we) begin
                e_cs_n  = (m_k >= RD);
                e_oe_n  = e_cs_n;
                e_state = (m_k < RD) ? 3'd1 : 3'd5;
                if (m_k == RD) begin e_hack = !m_port; e_dack = m_port; end
            end else begin
                e_cs_n  = (m_k > WR + 1);
                e_we_n  = !(m_k >= 1 && m_k <= WR);
                e_oe_en = (m_k <= WR + 1);
                if (m_k == 0)           e_state = 3'd2;
                else if (m_k <= WR)     e_state = 3'd3;
                else if (m_k == WR + 1) e_state = 3'd4;
                else                    e_state = 3'd5;
                if (m_k == WR + 1) begin e_hack = !m_port; e_dack = m_port; end
            end
        end
        chk("state", 32'(state), 32'(e_state));
        chk("cs_n", 32'(ram_cs_n), 32'(e_cs_n));
        chk("oe_n", 32'(ram_oe_n), 32'(e_oe_n));
        chk("we_n", 32'(ram_we_n), 32'(e_we_n));
        chk("oe_we_overlap", 32'(!ram_oe_n && !ram_we_n), 32'd0);
        chk("lb_n", 32'(ram_lb_n), 32'(e_cs_n | !m_be[0]));
        chk("ub_n", 32'(ram_ub_n), 32'(e_cs_n | !m_be[1]));
        chk("oe_en", 32'(sram_oe_en), 32'(e_oe_en));
        chk("h_ack", 32'(h_ack), 32'(e_hack));
        chk("d_ack", 32'(d_ack), 32'(e_dack));
        chk("h_rdata", 32'(h_rdata), 32'(m_h_rdata));
        chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
        if (!e_cs_n)  chk("addr", 32'(sram_addr), 32'(m_addr));
        if (e_oe_en)  chk("dout", 32'(sram_dout), 32'(m_wdata));
        if (h_ack === 1'b1) sb_match(1'b0, h_rdata);
        if (d_ack === 1'b1) sb_match(1'b1, d_rdata);
        if (ram_we_n === 1'b0)   n_we_low++;
        if (sram_oe_en === 1'b1) n_oe_en++;
        if (d_ack === 1'b1)      n_dack++;
    endtask

    // Requesters retire their head request on the cycle its ack is due.
    task automatic retire();
        if (m_busy && ((!m_we && m_k == RD) || (m_we && m_k == WR + 1))) begin
            if (m_port) void'(dq.pop_front());
            else        void'(hq.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        retire();
        drive_ports();
    endtask

    task automatic drain();
        int budget;
        budget = 2000;
        while ((hq.size() != 0 || dq.size() != 0 || m_busy) && budget > 0) begin
            step();
            budget--;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cs_n"},  32'(ram_cs_n),  32'd1);
        chk({tag, "_oe_n"},  32'(ram_oe_n),  32'd1);
        chk({tag, "_we_n"},  32'(ram_we_n),  32'd1);
        chk({tag, "_lb_n"},  32'(ram_lb_n),  32'd1);
        chk({tag, "_ub_n"},  32'(ram_ub_n),  32'd1);
        chk({tag, "_oe_en"}, 32'(sram_oe_en), 32'd0);
        chk({tag, "_h_ack"}, 32'(h_ack),     32'd0);
        chk({tag, "_d_ack"}, 32'(d_ack),     32'd0);
        chk({tag, "_addr"},  32'(sram_addr), 32'd0);
        chk({tag, "_dout"},  32'(sram_dout), 32'd0);
        chk({tag, "_state"}, 32'(state),     32'd0);
        chk({tag, "_h_rdata"}, 32'(h_rdata), 32'd0);
        chk({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        txn_t t;
        int   budget;

        for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
        mem[18'h12345] = 16'hBEEF;
        model_reset();
        log_en = 0;

        // Reset held with a host read already requested.
        reset = 1'b0;
        t.we = 1'b0; t.be = 2'b11; t.addr = 18'h12345; t.wdata = 16'h0;
        hq.push_back(t);
        drive_ports();
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst");
            check_cycle();
        end
        reset = 1'b1;

        // H read of 0x1_2345; granted at the first edge after release.
        drain();
        chk("h_read_beef", 32'(h_rdata), 32'h0000BEEF);

        // D write, lower byte only.
        n_we_low = 0; n_oe_en = 0; n_dack = 0;
        t.we = 1'b1; t.be = 2'b01; t.addr = 18'h00007; t.wdata = 16'hA55A;
        dq.push_back(t);
        drive_ports();
        drain();
        chk("d_wr_we_low_cycles", 32'(n_we_low), 32'(WR));
        chk("d_wr_oe_en_cycles",  32'(n_oe_en),  32'(WR + 2));
        chk("d_wr_ack_count",     32'(n_dack),   32'd1);

        // be = 00 read, followed by back-to-back host reads.
        t.we = 1'b0; t.be = 2'b00; t.addr = 18'h00007; t.wdata = 16'h0;
        hq.push_back(t);
        t.be = 2'b11; t.addr = 18'h00007; hq.push_back(t);
        t.be = 2'b10; t.addr = 18'h00003; hq.push_back(t);
        drive_ports();
        drain();

        // Reset asserted during the write pulse.
        t.we = 1'b1; t.be = 2'b11; t.addr = 18'h00009; t.wdata = 16'h1234;
        dq.push_back(t);
        drive_ports();
        budget = 50;
        while (!(m_busy && m_we && m_k == 2) && budget > 0) begin
            step();
            budget--;
        end
        reset = 1'b0;
        #1;
        chk("midrst_we_n", 32'(ram_we_n), 32'd1);
        chk("midrst_cs_n", 32'(ram_cs_n), 32'd1);
        model_reset();
        @(negedge clk);
        check_reset_vals("midrst");
        check_cycle();
        reset = 1'b1;
        drain();
        chk("midrst_write_done", 32'(mem[18'h00009]), 32'h00001234);

        // Both ports busy: H,H,H,H,D pattern.
        for (int i = 0; i < 10; i++) begin
            t = rand_txn(); hq.push_back(t);
        end
        for (int i = 0; i < 2; i++) begin
            t = rand_txn(); dq.push_back(t);
        end
        ack_log.delete();
        log_en = 1;
        drive_ports();
        drain();
        log_en = 0;
        chk("starve_log_len", 32'(ack_log.size()), 32'd12);
        for (int i = 0; i < ack_log.size() && i < 12; i++)
            chk($sformatf("starve_order_%0d", i), 32'(ack_log[i]), 32'((i % 5) == 4));

        // Randomized traffic on both ports.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) hq.push_back(rand_txn());
            if ($urandom_range(0, 2) == 0) dq.push_back(rand_txn());
            drive_ports();
            repeat ($urandom_range(1, 6)) step();
        end
        drain();
        chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
